// File: rtl/matrix_scroll_scan.sv
// Scrolling 5x7 LED matrix back-end: 5x16 frame buffer, 7-column window at a scroll offset.
// Optional GHOST_BLANK_EN blanks the outputs for one cycle on every column change.
module matrix_scroll_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int STEP_DIV = 50,
  parameter int MSG_COLS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ch1,
  input  logic        ch0,
  input  logic        load,
  input  logic [79:0] msg_in,
  output logic [6:0]  acender_coluna,
  output logic [4:0]  linhas,
  output logic [3:0]  offset,
  output logic        frame_tick
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [4:0][MSG_COLS-1:0] rows;
  logic [DW-1:0]            div_cnt;
  logic [2:0]               col_idx;
  logic [SW-1:0]            step_cnt;

  logic       col_wrap, frame_wrap, step_wrap, step;
  logic [3:0] msg_col;
  logic [4:0] col_bits;

  assign col_wrap   = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_wrap = col_wrap && (col_idx == 3'd6);
  assign step_wrap  = (step_cnt == SW'(STEP_DIV - 1));
  assign step       = frame_wrap && step_wrap;
  // 4-bit add gives the seamless mod-16 wrap of the message window
  assign msg_col    = offset + {1'b0, col_idx};

  always_comb begin
    col_bits = '0;
    for (int r = 0; r < 5; r++) col_bits[r] = rows[r][msg_col];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows           <= '0;
      div_cnt        <= '0;
      col_idx        <= '0;
      step_cnt       <= '0;
      offset         <= '0;
      acender_coluna <= 7'h7F;
      linhas         <= '0;
      frame_tick     <= 1'b0;
    end else begin
      div_cnt    <= col_wrap ? '0 : div_cnt + 1'b1;
      frame_tick <= frame_wrap;
      if (col_wrap) col_idx <= (col_idx == 3'd6) ? 3'd0 : col_idx + 3'd1;

`ifdef GHOST_BLANK_EN
      if (col_wrap) begin
        acender_coluna <= 7'h7F;
        linhas         <= '0;
      end else begin
        acender_coluna <= ~(7'd1 << col_idx);
        linhas         <= col_bits;
      end
`else
      acender_coluna <= ~(7'd1 << col_idx);
      linhas         <= col_bits;
`endif

      // load overrides any step landing on the same edge
      if (load) begin
        rows     <= msg_in;
        offset   <= '0;
        step_cnt <= '0;
      end else begin
        if (frame_wrap) step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
        case ({ch1, ch0})
          2'b00:   offset <= '0;
          2'b01:   if (step) offset <= offset + 4'd1;
          2'b10:   if (step) offset <= offset - 4'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_scroll_scan.sv
// Randomized scoreboard bench: two configurations of matrix_scroll_scan against an arithmetic model.
module tb_matrix_scroll_scan;
  logic        clk = 1'b0;
  logic        reset, ch1, ch0, load;
  logic [79:0] msg_in;
  logic [6:0]  str0, str1;
  logic [4:0]  lin0, lin1;
  logic [3:0]  off0, off1;
  logic        ft0, ft1;

  always #5 clk = ~clk;

  matrix_scroll_scan #(.SCAN_DIV(2), .STEP_DIV(1), .MSG_COLS(16)) dut0 (
    .clk(clk), .reset(reset), .ch1(ch1), .ch0(ch0), .load(load), .msg_in(msg_in),
    .acender_coluna(str0), .linhas(lin0), .offset(off0), .frame_tick(ft0));
  matrix_scroll_scan #(.SCAN_DIV(3), .STEP_DIV(4), .MSG_COLS(16)) dut1 (
    .clk(clk), .reset(reset), .ch1(ch1), .ch0(ch0), .load(load), .msg_in(msg_in),
    .acender_coluna(str1), .linhas(lin1), .offset(off1), .frame_tick(ft1));

  function automatic int sdv(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int stv(input int i); return (i == 0) ? 1 : 4; endfunction

  typedef struct packed {
    logic [6:0] s;
    logic [4:0] l;
    logic [3:0] o;
    logic       f;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          m_dv[2], m_cl[2], m_sc[2], m_of[2];
  logic [79:0] m_buf = '0;
  int          checks = 0, fails = 0;

  // Model: cycle count within column, column index, frames since step, offset as integers.
  always @(posedge clk) begin
    exp_t e;
    bit wrap, ftk, stp;
    for (int i = 0; i < 2; i++) begin
      e = '0;
      if (reset) begin
        e.s = 7'h7F;
        m_dv[i] = 0; m_cl[i] = 0; m_sc[i] = 0; m_of[i] = 0;
      end else begin
        wrap = (m_dv[i] == sdv(i) - 1);
        ftk  = wrap && (m_cl[i] == 6);
        stp  = ftk && (m_sc[i] == stv(i) - 1);
        e.s = 7'h7F;
        e.s[m_cl[i]] = 1'b0;
        for (int r = 0; r < 5; r++) e.l[r] = m_buf[r*16 + (m_of[i] + m_cl[i]) % 16];
`ifdef GHOST_BLANK_EN
        if (wrap) begin e.s = 7'h7F; e.l = '0; end
`endif
        e.f = ftk;
        m_dv[i] = (m_dv[i] + 1) % sdv(i);
        if (wrap) m_cl[i] = (m_cl[i] + 1) % 7;
        if (load) begin
          m_of[i] = 0; m_sc[i] = 0;
        end else begin
          if (ftk) m_sc[i] = (m_sc[i] + 1) % stv(i);
          case ({ch1, ch0})
            2'b00: m_of[i] = 0;
            2'b01: if (stp) m_of[i] = (m_of[i] + 1) % 16;
            2'b10: if (stp) m_of[i] = (m_of[i] + 15) % 16;
            default: ;
          endcase
        end
        e.o = 4'(m_of[i]);
      end
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (reset) m_buf = '0; else if (load) m_buf = msg_in;
  end

  task automatic chk(input int i, input logic [6:0] s, input logic [4:0] l,
                     input logic [3:0] o, input logic f, input exp_t e);
    checks += 4;
    if (s !== e.s) begin fails++; $display("FAIL inst%0d strobe t=%0t got %h want %h", i, $time, s, e.s); end
    if (l !== e.l) begin fails++; $display("FAIL inst%0d linhas t=%0t got %b want %b", i, $time, l, e.l); end
    if (o !== e.o) begin fails++; $display("FAIL inst%0d offset t=%0t got %0d want %0d", i, $time, o, e.o); end
    if (f !== e.f) begin fails++; $display("FAIL inst%0d frame_tick t=%0t got %b want %b", i, $time, f, e.f); end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); chk(0, str0, lin0, off0, ft0, e); end
    if (q1.size() > 0) begin e = q1.pop_front(); chk(1, str1, lin1, off1, ft1, e); end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    {ch1, ch0} = m;
  endtask

  initial begin
    int guard;
    reset = 1'b1; ch1 = 1'b0; ch0 = 1'b0; load = 1'b0; msg_in = '0;
    cyc(3);
    reset = 1'b0;
    cyc(30);
    // row0 = 0001: only column 0 lit in static mode
    msg_in = 80'h0001; load = 1'b1; cyc(1); load = 1'b0;
    cyc(60);
    set_mode(2'b01); cyc(260);
    set_mode(2'b00); cyc(2);
    set_mode(2'b10); cyc(50);
    set_mode(2'b01); cyc(75);
    set_mode(2'b11); cyc(150);
    set_mode(2'b01); cyc(31);
    // Load timed to coincide with a step edge of instance 0
    guard = 0;
    while (!(m_dv[0] == 1 && m_cl[0] == 6 && m_sc[0] == 0) && guard < 100) begin cyc(1); guard++; end
    checks++;
    if (guard >= 100) begin fails++; $display("FAIL step_align got timeout want step edge"); end
    msg_in = {$urandom, $urandom, $urandom}; load = 1'b1; cyc(1); load = 1'b0;
    cyc(40);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(39) == 0) set_mode(2'($urandom));
      load = ($urandom_range(24) == 0);
      if (load) msg_in = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
      reset = ($urandom_range(299) == 0);
      cyc(1);
    end
    load = 1'b0; reset = 1'b0; set_mode(2'b01);
    cyc(7);
    reset = 1'b1; cyc(1); reset = 1'b0;
    cyc(20);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
